reg_dump_ctrl: RTL and testbench

Read-side master for the CPU register file. It drives a read address into one register-file read port and captures the combinational read data. It then streams the selected register range out as bytes over a valid/ready interface, for debug and test observation. It sits beside the register file, takes over a spare read port (A2/RD2 path via mux, or a dedicated port), and never writes.

---
 rtl/reg_dump_if.sv | 34 +++
 rtl/reg_dump_ctrl.sv | 114 +++++++++++
 tb/tb_reg_dump_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_if.sv
// Register-dump bundle: register-file read port,
// byte stream toward the sink, and dump control/status.
interface reg_dump_if #(
  parameter int W  = 32,
  parameter int AW = 4
);
  logic          start;
  logic          abort;
  logic [AW-1:0] first_reg;
  logic [AW-1:0] last_reg;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  start, abort, first_reg, last_reg,
    input  rd_data, out_ready,
    output rd_addr, out_data, out_valid, out_last,
    output busy, done, err
  );

  modport slave (
    output start, abort, first_reg, last_reg,
    output rd_data, out_ready,
    input  rd_addr, out_data, out_valid, out_last,
    input  busy, done, err
  );
endinterface

// File: rtl/reg_dump_ctrl.sv
// Streams a register-file range out as bytes, LSB first,
// snapshotting each register on its LOAD cycle.
module reg_dump_ctrl #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  reg_dump_if.master  bus
);

  localparam int NB = W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_FIN
  } state_t;

  state_t        r_state, w_state_nx;
  logic [AW-1:0] r_rd_addr, w_rd_addr_nx;
  logic [AW-1:0] r_last, w_last_nx;
  logic [W-1:0]  r_shift, w_shift_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_err, w_err_nx;
  logic          w_valid;
  logic          w_hs;
  logic          w_last_byte;

  assign w_valid     = (r_state == S_SEND);
  assign w_hs        = w_valid && bus.out_ready;
  assign w_last_byte = (r_cnt == CW'(NB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_last    <= '0;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_rd_addr <= w_rd_addr_nx;
      r_last    <= w_last_nx;
      r_shift   <= w_shift_nx;
      r_cnt     <= w_cnt_nx;
      r_err     <= w_err_nx;
    end
  end

  // abort wins over a coincident handshake
  always_comb begin
    w_state_nx   = r_state;
    w_rd_addr_nx = r_rd_addr;
    w_last_nx    = r_last;
    w_shift_nx   = r_shift;
    w_cnt_nx     = r_cnt;
    w_err_nx     = 1'b0;
    if (r_state != S_IDLE && bus.abort) begin
      w_state_nx = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.first_reg <= bus.last_reg) begin
              w_rd_addr_nx = bus.first_reg;
              w_last_nx    = bus.last_reg;
              w_state_nx   = S_LOAD;
            end else begin
              w_err_nx = 1'b1;
            end
          end
        end
        S_LOAD: begin
          w_shift_nx = bus.rd_data;
          w_cnt_nx   = '0;
          w_state_nx = S_SEND;
        end
        S_SEND: begin
          if (w_hs) begin
            if (!w_last_byte) begin
              w_shift_nx = r_shift >> 8;
              w_cnt_nx   = r_cnt + CW'(1);
            end else if (r_rd_addr != r_last) begin
              w_rd_addr_nx = r_rd_addr + AW'(1);
              w_state_nx   = S_LOAD;
            end else begin
              w_state_nx = S_FIN;
            end
          end
        end
        S_FIN: begin
          w_state_nx = S_IDLE;
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_addr   = r_rd_addr;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_valid ? r_shift[7:0] : 8'h00;
  assign bus.out_last  = w_valid && w_last_byte
                         && (r_rd_addr == r_last);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_FIN);
  assign bus.err       = r_err;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Scoreboard bench for reg_dump_ctrl: expected bytes are
// queued at start and popped on each sink handshake.
module tb_reg_dump_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_dump_if #(.W(32), .AW(4)) bus();

  reg_dump_ctrl #(.W(32), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] regs [16];
  assign bus.rd_data = regs[bus.rd_addr];

  logic [8:0] q [$];
  int n_pass  = 0;
  int n_total = 0;

  logic       stalled;
  logic [7:0] p_data;
  logic       p_last;
  logic [3:0] p_addr;

  task automatic fill_pattern();
    for (int r = 0; r < 16; r++)
      regs[r] = {4{4'h0, 4'(r)}};
  endtask

  task automatic push_range(input int f, input int l,
                            input int dl);
    for (int r = f; r <= l; r++)
      for (int b = 0; b < 4; b++)
        q.push_back({(r == dl && b == 3),
                     regs[r][8*b +: 8]});
  endtask

  task automatic kick(input logic [3:0] f,
                      input logic [3:0] l);
    stalled       = 1'b0;
    bus.first_reg = f;
    bus.last_reg  = l;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  // one cycle: drive ready, check stall stability, score handshake
  task automatic step(input logic rdy);
    logic [8:0] e;
    bus.out_ready = rdy;
    if (stalled) begin
      n_total++;
      if ({bus.out_valid, bus.out_last, bus.out_data,
           bus.rd_addr} !== {1'b1, p_last, p_data, p_addr})
        $display("FAIL stall_hold: got v%b l%b %h a%0d want l%b %h a%0d",
                 bus.out_valid, bus.out_last, bus.out_data,
                 bus.rd_addr, p_last, p_data, p_addr);
      else n_pass++;
    end
    if (bus.out_valid && rdy) begin
      n_total++;
      if (q.size() == 0) begin
        $display("FAIL extra_byte: got %h want none",
                 bus.out_data);
      end else begin
        e = q.pop_front();
        if ({bus.out_last, bus.out_data} !== e)
          $display("FAIL byte: got last=%b %h want last=%b %h",
                   bus.out_last, bus.out_data, e[8], e[7:0]);
        else n_pass++;
      end
    end
    stalled = bus.out_valid && !rdy;
    p_data  = bus.out_data;
    p_last  = bus.out_last;
    p_addr  = bus.rd_addr;
    @(negedge clk);
  endtask

  task automatic drain(input int budget, output int steps);
    steps = 0;
    while (q.size() > 0 && steps < budget) begin
      step(1'b1);
      steps++;
    end
    n_total++;
    if (q.size() != 0)
      $display("FAIL drain_timeout: got %0d left want 0",
               q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if ({bus.rd_addr, bus.out_data, bus.out_valid,
         bus.out_last, bus.busy, bus.done, bus.err} !== '0)
      $display("FAIL reset_outs: got a%0d d%h v%b l%b b%b dn%b e%b want 0",
               bus.rd_addr, bus.out_data, bus.out_valid,
               bus.out_last, bus.busy, bus.done, bus.err);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0)
      $display("FAIL reset_idle: got busy=%b want 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_full_dump();
    int s;
    fill_pattern();
    push_range(0, 15, 15);
    kick(4'd0, 4'd15);
    drain(200, s);
    n_total++;
    if (s != 80)
      $display("FAIL full_cycles: got %0d want 80", s);
    else n_pass++;
    n_total++;
    if ({bus.done, bus.out_valid} !== 2'b10)
      $display("FAIL full_done: got done=%b v=%b want 1 0",
               bus.done, bus.out_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({bus.done, bus.busy} !== 2'b00)
      $display("FAIL full_idle: got done=%b busy=%b want 0 0",
               bus.done, bus.busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int s;
    regs[3] = 32'hDEADBEEF;
    push_range(3, 3, 3);
    kick(4'd3, 4'd3);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    drain(20, s);
    n_total++;
    if (bus.done !== 1'b1)
      $display("FAIL bp_done: got %b want 1", bus.done);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_snapshot();
    int s;
    regs[5] = 32'h11223344;
    push_range(5, 5, 5);
    kick(4'd5, 4'd5);
    step(1'b1);
    regs[5] = 32'hFFFFFFFF;
    step(1'b0);
    drain(20, s);
    n_total++;
    if (bus.done !== 1'b1)
      $display("FAIL snap_done: got %b want 1", bus.done);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_range_error();
    int seen;
    kick(4'd9, 4'd4);
    n_total++;
    if ({bus.err, bus.busy, bus.out_valid} !== 3'b100)
      $display("FAIL err_pulse: got e%b b%b v%b want 1 0 0",
               bus.err, bus.busy, bus.out_valid);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.err || bus.busy || bus.out_valid) seen++;
    end
    n_total++;
    if (seen != 0)
      $display("FAIL err_after: got %0d active cycles want 0",
               seen);
    else n_pass++;
  endtask

  task automatic test_abort();
    int s;
    int dn;
    fill_pattern();
    push_range(0, 1, 15);
    q.push_back({1'b0, regs[2][7:0]});
    q.push_back({1'b0, regs[2][15:8]});
    kick(4'd0, 4'd15);
    drain(100, s);
    n_total++;
    if ({bus.out_valid, bus.out_data, bus.rd_addr}
        !== {1'b1, 8'h02, 4'd2})
      $display("FAIL abort_pre: got v%b %h a%0d want 1 02 2",
               bus.out_valid, bus.out_data, bus.rd_addr);
    else n_pass++;
    bus.abort     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.abort     = 1'b0;
    n_total++;
    if ({bus.out_valid, bus.out_last, bus.busy, bus.done}
        !== 4'b0000)
      $display("FAIL abort_stop: got v%b l%b b%b d%b want 0",
               bus.out_valid, bus.out_last, bus.busy, bus.done);
    else n_pass++;
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done || bus.out_valid) dn++;
      @(negedge clk);
    end
    n_total++;
    if (dn != 0)
      $display("FAIL abort_quiet: got %0d active want 0", dn);
    else n_pass++;
    push_range(7, 7, 7);
    kick(4'd7, 4'd7);
    drain(20, s);
    n_total++;
    if (bus.done !== 1'b1)
      $display("FAIL abort_restart: got done=%b want 1",
               bus.done);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int s;
    push_range(0, 9, 15);
    kick(4'd0, 4'd15);
    drain(100, s);
    n_total++;
    if ({bus.rd_addr, bus.busy} !== {4'd10, 1'b1})
      $display("FAIL rst_pre: got a%0d b%b want 10 1",
               bus.rd_addr, bus.busy);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({bus.rd_addr, bus.out_data, bus.out_valid,
         bus.out_last, bus.busy, bus.done, bus.err} !== '0)
      $display("FAIL rst_mid: got a%0d d%h v%b l%b b%b dn%b want 0",
               bus.rd_addr, bus.out_data, bus.out_valid,
               bus.out_last, bus.busy, bus.done);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.done, bus.busy} !== 2'b00)
      $display("FAIL rst_after: got d%b b%b want 0 0",
               bus.done, bus.busy);
    else n_pass++;
  endtask

  task automatic test_r15();
    int s;
    fill_pattern();
    push_range(14, 15, 15);
    kick(4'd14, 4'd15);
    drain(40, s);
    n_total++;
    if (s != 10)
      $display("FAIL r15_cycles: got %0d want 10", s);
    else n_pass++;
    n_total++;
    if ({bus.rd_addr, bus.done} !== {4'd15, 1'b1})
      $display("FAIL r15_fin: got a%0d d%b want 15 1",
               bus.rd_addr, bus.done);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({bus.rd_addr, bus.busy} !== {4'd15, 1'b0})
      $display("FAIL r15_hold: got a%0d b%b want 15 0",
               bus.rd_addr, bus.busy);
    else n_pass++;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.first_reg = '0;
    bus.last_reg  = '0;
    bus.out_ready = 1'b0;
    stalled       = 1'b0;
    p_data        = '0;
    p_last        = 1'b0;
    p_addr        = '0;
    fill_pattern();
    test_reset();
    test_full_dump();
    test_backpressure();
    test_snapshot();
    test_range_error();
    test_abort();
    test_reset_mid();
    q.delete();
    test_r15();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
